uart_tx_arbiter: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side request bus and transmitter-side byte handshake.
// master: producers plus transmitter (the environment); slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*8-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         tx_din;
    logic               tx_wr_en;
    logic               tx_busy;

    modport master (
        output req, req_data, tx_busy,
        input  ack, tx_din, tx_wr_en
    );

    modport slave (
        input  req, req_data, tx_busy,
        output ack, tx_din, tx_wr_en
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first asserted request after last_grant,
// wrapping modulo N_REQ. Kept standalone so RX dispatch can reuse it.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Scan farthest candidate first so the nearest one after last_grant wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            pos = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ producers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line free; grant to next requester when en and !tx_busy
// ISSUE     | one cycle: tx_wr_en and ack[winner] asserted
// WAIT_BUSY | waiting for tx_busy to rise; timer guards against a dead TX
// WAIT_DONE | frame on the wire; tx_busy falling ends the frame
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic                en,
    uart_tx_arbiter_if.slave    bus,
    output logic [IDX_W-1:0]    cur_src,
    output logic                active,
    output logic                tx_done,
    output logic                err_timeout
);

    // Down-counter loaded with TIMEOUT_CYC-1; fault when it reaches zero
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] cur_src_q, cur_src_d;
    logic [7:0]       tx_din_q, tx_din_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             tx_wr_en_q, tx_wr_en_d;
    logic             active_q, active_d;
    logic             tx_done_q, tx_done_d;
    logic             err_timeout_q, err_timeout_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    // Next-state and registered-output logic; pulses default low every cycle
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        last_grant_d  = last_grant_q;
        cur_src_d     = cur_src_q;
        tx_din_d      = tx_din_q;
        active_d      = active_q;
        ack_d         = '0;
        tx_wr_en_d    = 1'b0;
        tx_done_d     = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en && pick_valid && !bus.tx_busy) begin
                    tx_din_d        = bus.req_data[{pick_idx, 3'b000} +: 8];
                    cur_src_d       = pick_idx;
                    active_d        = 1'b1;
                    ack_d[pick_idx] = 1'b1;
                    tx_wr_en_d      = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = TMR_W'(TIMEOUT_CYC - 1);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == '0) begin
                    err_timeout_d = 1'b1;
                    last_grant_d  = cur_src_q;
                    active_d      = 1'b0;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    tx_done_d    = 1'b1;
                    last_grant_d = cur_src_q;
                    active_d     = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; synchronous reset gives requester 0 first priority
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            last_grant_q  <= IDX_W'(N_REQ - 1);
            cur_src_q     <= '0;
            tx_din_q      <= 8'h00;
            ack_q         <= '0;
            tx_wr_en_q    <= 1'b0;
            active_q      <= 1'b0;
            tx_done_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_grant_q  <= last_grant_d;
            cur_src_q     <= cur_src_d;
            tx_din_q      <= tx_din_d;
            ack_q         <= ack_d;
            tx_wr_en_q    <= tx_wr_en_d;
            active_q      <= active_d;
            tx_done_q     <= tx_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.tx_wr_en = tx_wr_en_q;
    assign cur_src      = cur_src_q;
    assign active       = active_q;
    assign tx_done      = tx_done_q;
    assign err_timeout  = err_timeout_q;

endmodule
